serial_adder: RTL

- Bit-serial N-bit adder that consumes the sum/carry outputs of two halfadder instances, chained as a full adder, plus a registered carry.
- Accepts two parallel operands on a start strobe.
- Processes one bit per clock, LSB first.
- Presents the parallel N-bit sum and carry-out with a one-cycle done pulse.
- Sits directly downstream of halfadder in the lab datapath: the sequential stage that turns the single-bit combinational cell into a multi-bit adder.

---
 rtl/serial_adder.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial N-bit adder. Two halfadder cells are chained as a full adder
//   and a registered carry closes the loop, so one result bit is produced
//   per clock, LSB first. Operands are captured on a start strobe. The
//   parallel sum and carry-out are presented with a one-cycle done pulse.
//
//   Parameters:
//     N      operand/result width in bits (2..32), default 8
//
//   Ports:
//     clk    in   1  system clock, rising edge
//     rst    in   1  synchronous active-high reset
//     start  in   1  request strobe, sampled only while idle
//     sub    in   1  (SERIAL_ADDER_SUB_EN only) subtract a - b, captured with start
//     a      in   N  operand A, captured on accepted start
//     b      in   N  operand B, captured on accepted start
//     busy   out  1  high while an operation is running or completing
//     done   out  1  one-cycle pulse, sum/cout valid from this cycle on
//     sum    out  N  registered result, held until the next completion
//     cout   out  1  registered carry-out of bit N-1, held with sum
//
//   Optional feature macro: SERIAL_ADDER_SUB_EN
//     Adds the sub port. With sub=1, B is loaded inverted and the carry
//     starts at 1 (two's complement), so sum = a - b mod 2^N and cout=1
//     means no borrow. Cycle timing is the same in both builds.
// ---------------------------------------------------------------------------

// Single-bit combinational half adder cell.
module halfadder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic         sub,
`endif
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state, state_nxt;

  logic [N-1:0]   a_sh, b_sh, res_sh;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           last_bit;

  logic           s1, c1, s2, c2;
  logic [N-1:0]   b_load;
  logic           carry_init;

  // Full adder built from the two unmodified half adder cells.
  halfadder u_ha0 (.a(a_sh[0]), .b(b_sh[0]), .s(s1), .c(c1));
  halfadder u_ha1 (.a(s1),      .b(carry),   .s(s2), .c(c2));

  assign last_bit = (cnt == CW'(N - 1));

`ifdef SERIAL_ADDER_SUB_EN
  // Two's complement subtraction: a + ~b + 1.
  assign b_load     = sub ? ~b : b;
  assign carry_init = sub;
`else
  assign b_load     = b;
  assign carry_init = 1'b0;
`endif

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status outputs.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand shift registers, carry flop, bit counter, result.
  // NOTE: these are plain flops, not a memory array, so they are all
  // cleared by reset; a mid-operation reset must not leak stale bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b_load;
            res_sh <= '0;
            carry  <= carry_init;
            cnt    <= '0;
          end
        end
        RUN: begin
          // New bit enters at the MSB; after N shifts bit 0 sits at the LSB.
          res_sh <= {s2, res_sh[N-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= c1 | c2;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            sum  <= {s2, res_sh[N-1:1]};
            cout <= c1 | c2;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
